load_counter_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit reloading counter among NUM_REQ requesters. The winning requester's load value is loaded into the counter. The counter then counts up and reloads that value after each 0xF, for HOLD_WRAPS wraps, before the counter is released. It sits between the requesting agents and the shared counter datapath and owns that datapath's load/run sequencing.

---
 rtl/load_counter_sched.sv | 127 ++++++++++++
 tb/tb_load_counter_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_counter_sched.sv
// Round-robin owner of a shared 4-bit reloading counter: load at grant, wrap back to the
// load value HOLD_WRAPS times, then release. Optional owner abort: LOAD_COUNTER_SCHED_ABORT_EN.
module load_counter_sched #(
    parameter int NUM_REQ    = 4,
    parameter int HOLD_WRAPS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [4*NUM_REQ-1:0]       load_val_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic [3:0]                 count_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int WW = $clog2(HOLD_WRAPS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WW-1:0] LAST_WRAP = WW'(HOLD_WRAPS - 1);
    localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_rr_ptr;
    logic [3:0]         r_count;
    logic [3:0]         r_reload;
    logic [WW-1:0]      r_wraps;
    logic               r_done;

    logic [3:0]         w_load_arr [NUM_REQ];
    logic [OW-1:0]      w_cand;
    logic [OW-1:0]      w_winner;
    logic               w_found;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [OW-1:0]      w_next_ptr;
    logic               w_abort;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_load
        assign w_load_arr[g] = load_val_i[4*g +: 4];
    end

    // Scan NUM_REQ candidates starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every variable gets a default before the loop, otherwise a latch is inferred.
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_cand   = r_rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
            w_cand = (w_cand == LAST_REQ) ? '0 : w_cand + 1'b1;
        end
    end

    assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_next_ptr   = (r_owner == LAST_REQ) ? '0 : r_owner + 1'b1;

`ifdef LOAD_COUNTER_SCHED_ABORT_EN
    assign w_abort = !req_i[r_owner];
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_count  <= '0;
            r_reload <= '0;
            r_wraps  <= '0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state  <= ST_RUN;
                        r_gnt    <= w_win_onehot;
                        r_owner  <= w_winner;
                        r_count  <= w_load_arr[w_winner];
                        r_reload <= w_load_arr[w_winner];
                        r_wraps  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        // Abort leaves the counter frozen and wins over completion.
                        r_state  <= ST_IDLE;
                        r_gnt    <= '0;
                        r_rr_ptr <= w_next_ptr;
                    end else if (r_count == 4'hF) begin
                        r_count <= r_reload;
                        if (r_wraps == LAST_WRAP) begin
                            r_state  <= ST_IDLE;
                            r_gnt    <= '0;
                            r_done   <= 1'b1;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_wraps <= r_wraps + 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o   = r_gnt;
    assign owner_o = r_owner;
    assign count_o = r_count;
    assign busy_o  = (r_state == ST_RUN);
    assign done_o  = r_done;

endmodule

// File: tb/tb_load_counter_sched.sv
// Scoreboard bench for load_counter_sched (NUM_REQ=4, HOLD_WRAPS=2); honours LOAD_COUNTER_SCHED_ABORT_EN.
module tb_load_counter_sched;

    localparam int NUM_REQ    = 4;
    localparam int HOLD_WRAPS = 2;

    // Observation as packed hex: cyc[27:12] gnt[11:8] owner[7:6] count[5:2] busy[1] done[0].
    typedef struct packed {
        logic [15:0] cyc;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [3:0]  count;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] load_val = '0;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [3:0]  count;
    logic        busy;
    logic        done;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    obs_t exp_q[$];
    obs_t mon_act;
    obs_t mon_exp;

    load_counter_sched #(.NUM_REQ(NUM_REQ), .HOLD_WRAPS(HOLD_WRAPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .load_val_i (load_val),
        .gnt_o      (gnt),
        .owner_o    (owner),
        .count_o    (count),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push_obs(input int c, input logic [3:0] g, input int k,
                                     input logic [3:0] cnt, input bit b, input bit d);
        obs_t o;
        o.cyc = 16'(c); o.gnt = g; o.owner = 2'(k); o.count = cnt; o.busy = b; o.done = d;
        exp_q.push_back(o);
    endfunction

    // One full grant: counts L..F repeated HOLD_WRAPS times, then the done cycle. Returns done cycle.
    function automatic int push_grant(input int k, input logic [3:0] l, input int s);
        int span = 16 - int'(l);
        int dur  = HOLD_WRAPS * span;
        for (int j = 0; j < dur; j++)
            push_obs(s + j, 4'(1 << k), k, 4'(int'(l) + (j % span)), 1'b1, 1'b0);
        push_obs(s + dur, 4'b0000, k, l, 1'b0, 1'b1);
        return s + dur;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !reset && (busy || done)) begin
            mon_act = '{cyc: 16'(cyc), gnt: gnt, owner: owner, count: count, busy: busy, done: done};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected nothing", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({gnt, owner, count, busy, done}), 32'd0);
    endtask

    // Reset mid-cycle, verify outputs clear at once, release on the next falling edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2 reset = 1'b1;
        req = '0;
        #1 check_zero(name);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int s;
        int e1;
        int e2;

        #3 check_zero("power_on_reset");
        @(negedge clk);
        reset = 1'b0;

        // Random traffic, then reset in the middle of a cycle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req      = 4'($urandom);
            load_val = 16'($urandom);
        end
        do_reset("reset_random");
        mon_en = 1'b1;

        // Single requester 0 with load C.
        req = 4'b0001; load_val = 16'h000C;
        s = cyc + 1;
        e1 = push_grant(0, 4'hC, s);
        wait_until(e1);
        req = '0;
        drain("drain_single");

        // All requesting with load E: order 0,1,2,3,0 with one idle cycle between grants.
        do_reset("reset_rr");
        req = 4'b1111; load_val = 16'hEEEE;
        s = cyc + 1;
        e1 = push_grant(0, 4'hE, s);
        e1 = push_grant(1, 4'hE, e1 + 1);
        e1 = push_grant(2, 4'hE, e1 + 1);
        e1 = push_grant(3, 4'hE, e1 + 1);
        e1 = push_grant(0, 4'hE, e1 + 1);
        wait_until(s + 20);
        req = 4'b0001;
        wait_until(e1);
        req = '0;
        drain("drain_rr");

        // Load F on requester 2: every run edge wraps.
        do_reset("reset_loadf");
        req = 4'b0100; load_val = 16'h0F00;
        s = cyc + 1;
        e1 = push_grant(2, 4'hF, s);
        wait_until(e1);
        req = '0;
        drain("drain_loadf");

        // Reset while running at count 7; pointer returns to requester 0.
        do_reset("reset_pre_run");
        req = 4'b0010; load_val = 16'h0050;
        s = cyc + 1;
        push_obs(s,     4'b0010, 1, 4'h5, 1'b1, 1'b0);
        push_obs(s + 1, 4'b0010, 1, 4'h6, 1'b1, 1'b0);
        push_obs(s + 2, 4'b0010, 1, 4'h7, 1'b1, 1'b0);
        wait_until(s + 2);
        #2 reset = 1'b1;
        #1 check_zero("reset_in_run");
        check("queue_at_reset", 32'(exp_q.size()), 32'd0);
        req = 4'b0011; load_val = 16'h005D;
        @(negedge clk);
        reset = 1'b0;
        e1 = push_grant(0, 4'hD, cyc + 1);
        wait_until(e1);
        req = '0;
        drain("drain_after_reset");

        // Owner 1 drops its request at count 9 while requester 2 waits.
        do_reset("reset_abort");
        req = 4'b0110; load_val = 16'h0A80;
        s = cyc + 1;
`ifdef LOAD_COUNTER_SCHED_ABORT_EN
        push_obs(s,     4'b0010, 1, 4'h8, 1'b1, 1'b0);
        push_obs(s + 1, 4'b0010, 1, 4'h9, 1'b1, 1'b0);
        e2 = push_grant(2, 4'hA, s + 3);
        wait_until(s + 1);
        req = 4'b0100;
        wait_until(s + 2);
        check("abort_state", 32'({gnt, owner, count, busy, done}),
              32'({4'b0000, 2'd1, 4'h9, 1'b0, 1'b0}));
`else
        e1 = push_grant(1, 4'h8, s);
        e2 = push_grant(2, 4'hA, e1 + 1);
        wait_until(s + 1);
        req = 4'b0100;
`endif
        wait_until(e2);
        req = '0;
        drain("drain_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
